// File: rtl/stall_flush_ctrl_pkg.sv
// Shared definitions for the IF/ID stall/flush controller.
//   sfc_state_e   : action recorded by the controller FSM each cycle
//   NOP_INSTR_DEF : instruction word loaded into IF/ID on flush and reset
//   CNT_W_DEF     : default width of the performance counters
package stall_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } sfc_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam int          CNT_W_DEF     = 32;

endpackage

// File: rtl/stall_flush_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
//   clk   : rising-edge clock
//   reset : synchronous clear to zero, wins over inc
//   inc   : add one this cycle unless already all-ones
//   count : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/stall_flush_ctrl.sv
// IF/ID pipeline register owner and stall/flush controller.
// Inputs : clk, reset (sync, active-high), data_hazard (stall request for the
//          instruction in ID), ID_Redirect (taken branch/jump in ID),
//          IF_Instruction / IF_PC_plus4 (fetched word and its PC+4).
// Outputs: PC_Write, ID_EX_Bubble (combinational), IF_ID_Instruction,
//          IF_ID_PC_plus4, IF_ID_Valid (registered IF/ID), stall_count,
//          flush_count (saturating), stall_timeout (sticky watchdog).
module stall_flush_ctrl
  import stall_flush_ctrl_pkg::*;
#(
  parameter int          CNT_W     = CNT_W_DEF,
  parameter int          MAX_STALL = 3,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_hazard,
  input  logic             ID_Redirect,
  input  logic [31:0]      IF_Instruction,
  input  logic [31:0]      IF_PC_plus4,
  output logic             PC_Write,
  output logic             ID_EX_Bubble,
  output logic [31:0]      IF_ID_Instruction,
  output logic [31:0]      IF_ID_PC_plus4,
  output logic             IF_ID_Valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_timeout
);

  localparam int             RUN_W   = $clog2(MAX_STALL + 1) + 1;
  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_STALL);

  logic             stall;
  logic             flush;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q,   pc4_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [RUN_W-1:0] stall_run;
  sfc_state_e       state_q, state_d;

  // A stalled instruction's operands are stale, so its redirect is not
  // trusted; an empty IF/ID can neither stall nor redirect.
  assign stall = data_hazard & valid_q;
  assign flush = ID_Redirect & valid_q & ~data_hazard;

  assign PC_Write     = ~stall;
  assign ID_EX_Bubble = stall | ~valid_q;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (stall) begin
      // hold all fields
    end else if (flush) begin
      instr_d = NOP_INSTR;
      pc4_d   = IF_PC_plus4;
      valid_d = 1'b0;
    end else begin
      instr_d = IF_Instruction;
      pc4_d   = IF_PC_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PC_plus4    = pc4_q;
  assign IF_ID_Valid       = valid_q;

  // FSM records the action taken in the cycle.
  always_comb begin
    state_d = ST_RUN;
    if (stall)      state_d = ST_STALL;
    else if (flush) state_d = ST_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // After a flush IF/ID is empty, so a second consecutive flush cannot occur.
  a_flush_single: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_FLUSH) |-> !flush);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_count)
  );

  // Length of the current consecutive stall run; any non-stall cycle clears it.
  sat_counter #(.W(RUN_W)) u_stall_run (
    .clk   (clk),
    .reset (reset | ~stall),
    .inc   (stall),
    .count (stall_run)
  );

  // Sticky: set when a stall continues past MAX_STALL cycles; does not
  // release the stall itself.
  assign timeout_d = timeout_q | (stall & (stall_run >= MAX_RUN));

  always_ff @(posedge clk) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_stall_flush_ctrl.sv
module tb_stall_flush_ctrl;

  localparam int MAX_STALL = 3;

  logic        clk;
  logic        reset;
  logic        data_hazard;
  logic        ID_Redirect;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC_plus4;

  logic        PC_Write, ID_EX_Bubble, IF_ID_Valid, stall_timeout;
  logic [31:0] IF_ID_Instruction, IF_ID_PC_plus4;
  logic [31:0] stall_count, flush_count;

  logic        PC_Write4, ID_EX_Bubble4, IF_ID_Valid4, stall_timeout4;
  logic [31:0] IF_ID_Instruction4, IF_ID_PC_plus44;
  logic [3:0]  stall_count4, flush_count4;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  int          m_sc, m_fc, m_run, m_st;
  bit          m_to;

  stall_flush_ctrl #(.CNT_W(32), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset), .data_hazard(data_hazard), .ID_Redirect(ID_Redirect),
    .IF_Instruction(IF_Instruction), .IF_PC_plus4(IF_PC_plus4),
    .PC_Write(PC_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_Valid(IF_ID_Valid), .stall_count(stall_count), .flush_count(flush_count),
    .stall_timeout(stall_timeout)
  );

  stall_flush_ctrl #(.CNT_W(4), .MAX_STALL(MAX_STALL)) dut4 (
    .clk(clk), .reset(reset), .data_hazard(data_hazard), .ID_Redirect(ID_Redirect),
    .IF_Instruction(IF_Instruction), .IF_PC_plus4(IF_PC_plus4),
    .PC_Write(PC_Write4), .ID_EX_Bubble(ID_EX_Bubble4),
    .IF_ID_Instruction(IF_ID_Instruction4), .IF_ID_PC_plus4(IF_ID_PC_plus44),
    .IF_ID_Valid(IF_ID_Valid4), .stall_count(stall_count4), .flush_count(flush_count4),
    .stall_timeout(stall_timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL time_limit: simulation exceeded time bound");
    $fatal(1, "time limit");
  end

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Apply inputs mid-cycle, let combinational outputs settle.
  task automatic drive(input bit rst, input bit hz, input bit rd,
                       input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    reset          = rst;
    data_hazard    = hz;
    ID_Redirect    = rd;
    IF_Instruction = ins;
    IF_PC_plus4    = pc;
    #1;
  endtask

  // Clock edge plus model update from the specification's rules.
  task automatic tick();
    bit s, f;
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_instr = 32'h0; m_pc = 32'h0;
      m_sc = 0; m_fc = 0; m_run = 0; m_to = 0; m_st = 0;
    end else begin
      s = data_hazard && m_valid;
      f = ID_Redirect && m_valid && !data_hazard;
      if (s) begin
        m_sc++;
        if (m_run >= MAX_STALL) m_to = 1;
        m_run++;
        m_st = 1;
      end else if (f) begin
        m_fc++;
        m_instr = 32'h0; m_pc = IF_PC_plus4; m_valid = 0;
        m_run = 0; m_st = 2;
      end else begin
        m_instr = IF_Instruction; m_pc = IF_PC_plus4; m_valid = 1;
        m_run = 0; m_st = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 32'hDEAD_BEEF, 32'h1234_5678);
    tick();
    drive(1, 0, 0, 32'h8C08_0004, 32'h0040_0004);
    tick();
    checks++;
    if (IF_ID_Instruction !== 32'h0 || IF_ID_PC_plus4 !== 32'h0 || IF_ID_Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ifid: instr=%h pc=%h valid=%b, need 0/0/0",
               IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid);
    end
    checks++;
    if (stall_count !== 0 || flush_count !== 0 || stall_timeout !== 1'b0 || dut.state_q !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrs: sc=%0d fc=%0d to=%b st=%0d, need 0/0/0/0",
               stall_count, flush_count, stall_timeout, dut.state_q);
    end
    drive(0, 0, 0, 32'h8C08_0004, 32'h0040_0004);
    checks++;
    if (IF_ID_Valid !== 1'b0 || ID_EX_Bubble !== 1'b1 || PC_Write !== 1'b1) begin
      errors++;
      $display("FAIL first_cycle: valid=%b bubble=%b pcw=%b, need 0/1/1",
               IF_ID_Valid, ID_EX_Bubble, PC_Write);
    end
    tick();
    checks++;
    if (IF_ID_Instruction !== 32'h8C08_0004 || IF_ID_PC_plus4 !== 32'h0040_0004 || IF_ID_Valid !== 1'b1) begin
      errors++;
      $display("FAIL first_load: instr=%h pc=%h valid=%b, need 8c080004/00400004/1",
               IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid);
    end
    drive(0, 0, 0, 32'h0000_1111, 32'h0040_0008);
    checks++;
    if (PC_Write !== 1'b1 || ID_EX_Bubble !== 1'b0) begin
      errors++;
      $display("FAIL run_ctrl: pcw=%b bubble=%b, need 1/0", PC_Write, ID_EX_Bubble);
    end
    tick();
  endtask

  task automatic test_single_stall();
    logic [31:0] held;
    held = IF_ID_Instruction;
    drive(0, 1, 0, 32'hAAAA_0001, 32'h0040_000C);
    checks++;
    if (PC_Write !== 1'b0 || ID_EX_Bubble !== 1'b1) begin
      errors++;
      $display("FAIL stall_ctrl: pcw=%b bubble=%b, need 0/1", PC_Write, ID_EX_Bubble);
    end
    tick();
    checks++;
    if (IF_ID_Instruction !== held || stall_count !== 1 || dut.state_q !== 2'd1) begin
      errors++;
      $display("FAIL single_stall: instr=%h sc=%0d st=%0d, need %h/1/1",
               IF_ID_Instruction, stall_count, dut.state_q, held);
    end
    drive(0, 0, 0, 32'hAAAA_0002, 32'h0040_0010);
    tick();
    checks++;
    if (dut.state_q !== 2'd0 || IF_ID_Instruction !== 32'hAAAA_0002) begin
      errors++;
      $display("FAIL stall_exit: st=%0d instr=%h, need 0/aaaa0002",
               dut.state_q, IF_ID_Instruction);
    end
  endtask

  task automatic test_double_stall();
    logic [31:0] held;
    held = IF_ID_Instruction;
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 32'hBBBB_0000 + k, 32'h0050_0000);
      tick();
    end
    checks++;
    if (IF_ID_Instruction !== held || stall_count !== 3 || stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL double_stall: instr=%h sc=%0d to=%b, need %h/3/0",
               IF_ID_Instruction, stall_count, stall_timeout, held);
    end
    drive(0, 0, 0, 32'hBBBB_0010, 32'h0050_0004);
    tick();
  endtask

  task automatic test_flush();
    drive(0, 0, 1, 32'h2009_0001, 32'h0060_0004);
    tick();
    checks++;
    if (IF_ID_Instruction !== 32'h0 || IF_ID_Valid !== 1'b0 || flush_count !== 1 ||
        IF_ID_PC_plus4 !== 32'h0060_0004 || dut.state_q !== 2'd2) begin
      errors++;
      $display("FAIL flush: instr=%h valid=%b fc=%0d pc=%h st=%0d, need 0/0/1/00600004/2",
               IF_ID_Instruction, IF_ID_Valid, flush_count, IF_ID_PC_plus4, dut.state_q);
    end
    drive(0, 0, 1, 32'h2009_0002, 32'h0060_0008);
    checks++;
    if (ID_EX_Bubble !== 1'b1) begin
      errors++;
      $display("FAIL post_flush_bubble: bubble=%b, need 1", ID_EX_Bubble);
    end
    tick();
    checks++;
    if (flush_count !== 1 || IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== 32'h2009_0002) begin
      errors++;
      $display("FAIL second_redirect: fc=%0d valid=%b instr=%h, need 1/1/20090002",
               flush_count, IF_ID_Valid, IF_ID_Instruction);
    end
  endtask

  task automatic test_simultaneous();
    int sc0;
    sc0 = m_sc;
    drive(0, 1, 1, 32'hCCCC_0001, 32'h0070_0004);
    checks++;
    if (PC_Write !== 1'b0) begin
      errors++;
      $display("FAIL simul_pcw: pcw=%b, need 0", PC_Write);
    end
    tick();
    checks++;
    if (flush_count !== 1 || IF_ID_Instruction !== 32'h2009_0002 || stall_count !== sc0 + 1) begin
      errors++;
      $display("FAIL simul: fc=%0d instr=%h sc=%0d, need 1/20090002/%0d",
               flush_count, IF_ID_Instruction, stall_count, sc0 + 1);
    end
    drive(0, 0, 0, 32'hCCCC_0002, 32'h0070_0008);
    tick();
  endtask

  task automatic test_watchdog();
    drive(1, 0, 0, 32'h0, 32'h0); tick();
    drive(0, 0, 0, 32'h1111_0000, 32'h0080_0004); tick();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0, 32'h2222_0000, 32'h0080_0008);
      tick();
      checks++;
      if (stall_timeout !== (k >= 4)) begin
        errors++;
        $display("FAIL watchdog_edge%0d: to=%b, need %b", k, stall_timeout, (k >= 4));
      end
    end
    checks++;
    if (IF_ID_Instruction !== 32'h1111_0000) begin
      errors++;
      $display("FAIL watchdog_hold: instr=%h, need 11110000", IF_ID_Instruction);
    end
    drive(0, 0, 0, 32'h3333_0000, 32'h0080_000C); tick();
    drive(0, 0, 0, 32'h3333_0004, 32'h0080_0010); tick();
    checks++;
    if (stall_timeout !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_sticky: to=%b, need 1", stall_timeout);
    end
    drive(1, 0, 0, 32'h0, 32'h0); tick();
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_clear: to=%b, need 0", stall_timeout);
    end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 32'h0, 32'h0); tick();
    drive(0, 0, 0, 32'h4444_0000, 32'h0090_0004); tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 32'h5555_0000, 32'h0090_0008);
      tick();
    end
    checks++;
    if (stall_count4 !== 4'd15 || stall_count !== 20) begin
      errors++;
      $display("FAIL saturation: sc4=%0d sc32=%0d, need 15/20", stall_count4, stall_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(0, 0, 0, 32'h6666_0000, 32'h00A0_0004); tick();
    drive(0, 1, 0, 32'h6666_0004, 32'h00A0_0008); tick();
    drive(1, 1, 1, 32'h6666_0008, 32'h00A0_000C); tick();
    drive(0, 1, 0, 32'h6666_000C, 32'h00A0_0010);
    checks++;
    if (PC_Write !== 1'b1 || IF_ID_Valid !== 1'b0 || ID_EX_Bubble !== 1'b1 || dut.state_q !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: pcw=%b valid=%b bubble=%b st=%0d, need 1/0/1/0",
               PC_Write, IF_ID_Valid, ID_EX_Bubble, dut.state_q);
    end
    tick();
  endtask

  task automatic test_random();
    bit hz, rd, rst, exp_pcw, exp_bub;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      hz  = (m_st == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 3) == 0);
      drive(rst, hz, rd, $urandom, $urandom);
      exp_pcw = !(hz && m_valid);
      exp_bub = (hz && m_valid) || !m_valid;
      checks++;
      if (PC_Write !== exp_pcw || ID_EX_Bubble !== exp_bub) begin
        errors++;
        $display("FAIL rnd_ctrl[%0d]: pcw=%b bubble=%b, need %b/%b",
                 n, PC_Write, ID_EX_Bubble, exp_pcw, exp_bub);
      end
      tick();
      checks++;
      if (IF_ID_Instruction !== m_instr || IF_ID_PC_plus4 !== m_pc || IF_ID_Valid !== m_valid) begin
        errors++;
        $display("FAIL rnd_ifid[%0d]: instr=%h pc=%h valid=%b, need %h/%h/%b",
                 n, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid, m_instr, m_pc, m_valid);
      end
      checks++;
      if (stall_count !== m_sc || flush_count !== m_fc || stall_count4 !== 4'(sat4(m_sc)) ||
          flush_count4 !== 4'(sat4(m_fc))) begin
        errors++;
        $display("FAIL rnd_ctrs[%0d]: sc=%0d fc=%0d sc4=%0d fc4=%0d, need %0d/%0d/%0d/%0d",
                 n, stall_count, flush_count, stall_count4, flush_count4,
                 m_sc, m_fc, sat4(m_sc), sat4(m_fc));
      end
      checks++;
      if (stall_timeout !== m_to || dut.state_q !== 2'(m_st)) begin
        errors++;
        $display("FAIL rnd_wd[%0d]: to=%b st=%0d, need %b/%0d",
                 n, stall_timeout, dut.state_q, m_to, m_st);
      end
    end
  endtask

  initial begin
    reset = 1'b1; data_hazard = 1'b0; ID_Redirect = 1'b0;
    IF_Instruction = 32'h0; IF_PC_plus4 = 32'h0;
    test_reset();
    test_single_stall();
    test_double_stall();
    test_flush();
    test_simultaneous();
    test_watchdog();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
